tusca_controle_n: RTL

TUSCA_CONTROLE_N -- requirements
Module: tusca_controle_n

---
 rtl/tusca_pkg.sv | 29 ++
 rtl/tusca_classificador.sv | 66 ++++++
 rtl/tusca_controle_n.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/tusca_pkg.sv
// tusca_pkg: shared FSM state codes and default parameter values.
// Purpose : one place for the controller's state enum and default constants.
// Latency : n/a (package). Backpressure: n/a.
package tusca_pkg;

  // State codes are visible on db_estado and must keep these values.
  typedef enum logic [3:0] {
    INICIAL        = 4'd0,
    MEDIR          = 4'd1,
    AGUARDA_MEDIDA = 4'd2,
    CLASSIFICA     = 4'd3,
    TRANSMITE      = 4'd4,
    AGUARDA_TX     = 4'd5,
    ESPERA_DELAY   = 4'd6,
    ERRO           = 4'd7
  } estado_t;

  localparam int N_NIVEIS_DEF       = 4;
  localparam int DATA_W_DEF         = 8;
  localparam int PERIODO_DELAY_DEF  = 100_000_000;
  localparam int TIMEOUT_DEF        = 50_000_000;
  localparam int MAX_TENTATIVAS_DEF = 3;
  localparam int HIST_DEF           = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tusca_classificador.sv
// tusca_classificador: temperature level from a set of thresholds.
// Latency : purely combinational. Backpressure: none.
// Ports   : temperatura (latched sample), lim_temp (slice i = threshold i),
//           nivel_atual (currently registered level), nivel_novo (proposed level).
// Config  : TUSCA_HISTERESE_EN enables hysteresis on downward level changes.
module tusca_classificador
  import tusca_pkg::*;
#(
  parameter int N_NIVEIS = N_NIVEIS_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int HIST     = HIST_DEF,
  parameter int NIV_W    = $clog2(N_NIVEIS_DEF + 1)
) (
  input  logic [DATA_W-1:0]          temperatura,
  input  logic [N_NIVEIS*DATA_W-1:0] lim_temp,
  input  logic [NIV_W-1:0]           nivel_atual,
  output logic [NIV_W-1:0]           nivel_novo
);

  logic [NIV_W-1:0] contagem;

  // Plain count of thresholds reached; order of thresholds is irrelevant.
  always_comb begin
    contagem = '0;
    for (int i = 0; i < N_NIVEIS; i++) begin
      if (temperatura >= lim_temp[i*DATA_W +: DATA_W]) begin
        contagem = contagem + NIV_W'(1);
      end
    end
  end

`ifdef TUSCA_HISTERESE_EN
  logic [DATA_W-1:0] lim_sel;
  int                lim_h;

  always_comb begin
    // Threshold that put us on the current level.
    lim_sel = '0;
    for (int i = 0; i < N_NIVEIS; i++) begin
      if (i + 1 == int'(nivel_atual)) begin
        lim_sel = lim_temp[i*DATA_W +: DATA_W];
      end
    end
    // Release point sits HIST below it, clamped at zero.
    lim_h = int'({1'b0, lim_sel}) - HIST;
    if (lim_h < 0) begin
      lim_h = 0;
    end

    if (contagem >= nivel_atual) begin
      nivel_novo = contagem;
    end else if (int'({1'b0, temperatura}) < lim_h) begin
      nivel_novo = nivel_atual - NIV_W'(1);
    end else begin
      nivel_novo = nivel_atual;
    end
  end
`else
  assign nivel_novo = contagem;

  // Current level and hysteresis width only matter with hysteresis enabled.
  logic unused_sinais;
  assign unused_sinais = (^nivel_atual) ^ (HIST != 0);
`endif

endmodule

// File: rtl/tusca_controle_n.sv
// tusca_controle_n: periodic measure / classify / report controller.
// Latency : level and relay registered one cycle after CLASSIFICA; one-cycle
//           medir/transmite request pulses. Backpressure: waits on sensor
//           (bounded by TIMEOUT, MAX_TENTATIVAS retries) and on report done (unbounded).
// Ports   : clock, reset (async active-low), start/parar pulses, sensor handshake
//           (medir, pronto_medida, erro_medida, temperatura, umidade), thresholds
//           (lim_temp, lim_umidade), results (nivel, rele, erro_timeout), report
//           handshake (transmite, pronto_transmissao), db_estado state code.
// Config  : TUSCA_HISTERESE_EN (see tusca_classificador).
module tusca_controle_n
  import tusca_pkg::*;
#(
  parameter int N_NIVEIS       = N_NIVEIS_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int PERIODO_DELAY  = PERIODO_DELAY_DEF,
  parameter int TIMEOUT        = TIMEOUT_DEF,
  parameter int MAX_TENTATIVAS = MAX_TENTATIVAS_DEF,
  parameter int HIST           = HIST_DEF
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             parar,
  output logic                             medir,
  input  logic                             pronto_medida,
  input  logic                             erro_medida,
  input  logic [DATA_W-1:0]                temperatura,
  input  logic [DATA_W-1:0]                umidade,
  input  logic [N_NIVEIS*DATA_W-1:0]       lim_temp,
  input  logic [DATA_W-1:0]                lim_umidade,
  output logic [$clog2(N_NIVEIS+1)-1:0]    nivel,
  output logic                             rele,
  output logic                             erro_timeout,
  output logic                             transmite,
  input  logic                             pronto_transmissao,
  output logic [3:0]                       db_estado
);

  localparam int NIV_W  = $clog2(N_NIVEIS + 1);
  localparam int CNT_W  = $clog2(max_int(PERIODO_DELAY, TIMEOUT) + 1);
  localparam int TENT_W = $clog2(MAX_TENTATIVAS + 1);

  estado_t           estado_q, estado_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TENT_W-1:0] tent_q, tent_d;
  logic [DATA_W-1:0] temp_q, temp_d;
  logic [DATA_W-1:0] umid_q, umid_d;
  logic [NIV_W-1:0]  nivel_q, nivel_d;
  logic              rele_q, rele_d;
  logic              erro_q, erro_d;

  logic [NIV_W-1:0]  nivel_calc;
  logic [CNT_W-1:0]  cnt_inc;
  logic [TENT_W-1:0] tent_inc;
  logic              fim_timeout, fim_delay, falha, esgotou;

  tusca_classificador #(
    .N_NIVEIS (N_NIVEIS),
    .DATA_W   (DATA_W),
    .HIST     (HIST),
    .NIV_W    (NIV_W)
  ) u_classificador (
    .temperatura (temp_q),
    .lim_temp    (lim_temp),
    .nivel_atual (nivel_q),
    .nivel_novo  (nivel_calc)
  );

  // Saturating increments; the counter is shared by the timeout and delay phases.
  assign cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
  assign tent_inc    = (tent_q == '1) ? tent_q : tent_q + TENT_W'(1);
  assign fim_timeout = (cnt_q == CNT_W'(TIMEOUT - 1));
  assign fim_delay   = (cnt_q == CNT_W'(PERIODO_DELAY - 1));
  assign falha       = erro_medida || fim_timeout;
  assign esgotou     = !(tent_inc < TENT_W'(MAX_TENTATIVAS));

  // State register and datapath flops.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q <= INICIAL;
      cnt_q    <= '0;
      tent_q   <= '0;
      temp_q   <= '0;
      umid_q   <= '0;
      nivel_q  <= '0;
      rele_q   <= 1'b0;
      erro_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      tent_q   <= tent_d;
      temp_q   <= temp_d;
      umid_q   <= umid_d;
      nivel_q  <= nivel_d;
      rele_q   <= rele_d;
      erro_q   <= erro_d;
    end
  end

  // Next state. parar overrides every other event; a valid sample beats a
  // simultaneous sensor error or timeout.
  always_comb begin
    estado_d = estado_q;
    if (parar) begin
      estado_d = INICIAL;
    end else begin
      case (estado_q)
        INICIAL:        if (start) estado_d = MEDIR;
        MEDIR:          estado_d = AGUARDA_MEDIDA;
        AGUARDA_MEDIDA: begin
          if (pronto_medida)  estado_d = CLASSIFICA;
          else if (falha)     estado_d = esgotou ? ERRO : MEDIR;
        end
        CLASSIFICA:     estado_d = TRANSMITE;
        TRANSMITE:      estado_d = AGUARDA_TX;
        AGUARDA_TX:     if (pronto_transmissao) estado_d = ESPERA_DELAY;
        ESPERA_DELAY:   if (fim_delay) estado_d = MEDIR;
        ERRO:           if (start) estado_d = MEDIR;
        default:        estado_d = INICIAL;
      endcase
    end
  end

  // Datapath updates tied to the current state.
  always_comb begin
    cnt_d   = cnt_q;
    tent_d  = tent_q;
    temp_d  = temp_q;
    umid_d  = umid_q;
    nivel_d = nivel_q;
    rele_d  = rele_q;
    erro_d  = erro_q;
    if (parar) begin
      rele_d = 1'b0;
    end else begin
      case (estado_q)
        INICIAL: begin
          if (start) begin
            tent_d = '0;
            erro_d = 1'b0;
          end
        end
        MEDIR: cnt_d = '0;
        AGUARDA_MEDIDA: begin
          if (pronto_medida) begin
            temp_d = temperatura;
            umid_d = umidade;
            tent_d = '0;
          end else if (falha) begin
            tent_d = tent_inc;
            if (esgotou) begin
              rele_d = 1'b0;
              erro_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end
        CLASSIFICA: begin
          nivel_d = nivel_calc;
          rele_d  = (umid_q >= lim_umidade);
        end
        // Hold the counter at zero so the delay phase starts counting from 0.
        AGUARDA_TX:   cnt_d = '0;
        ESPERA_DELAY: cnt_d = cnt_inc;
        ERRO: begin
          rele_d = 1'b0;
          if (start) begin
            erro_d = 1'b0;
            tent_d = '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Moore request pulses: each state lasts exactly one cycle.
  always_comb begin
    medir     = 1'b0;
    transmite = 1'b0;
    case (estado_q)
      MEDIR:     medir     = 1'b1;
      TRANSMITE: transmite = 1'b1;
      default:   ;
    endcase
  end

  assign nivel        = nivel_q;
  assign rele         = rele_q;
  assign erro_timeout = erro_q;
  assign db_estado    = estado_q;

endmodule
